// File: rtl/psw_adder_pipe_if.sv
// Operand/result bundle for psw_adder_pipe: valid/ready input beat, valid/ready result beat,
// overflow flags and the sticky-clear strobe. The slave modport is the adder side.
interface psw_adder_pipe_if #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
);
  localparam int LANES = WIDTH / LANE;

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] SubSum;
  logic [LANES-1:0] LaneOvf;
  logic             Overflow;
  logic             StickyOvf;
  logic             ClrSticky;

  modport master (
    output InValid, A, B, Sub, OutReady, ClrSticky,
    input  InReady, OutValid, SubSum, LaneOvf, Overflow, StickyOvf
  );

  modport slave (
    input  InValid, A, B, Sub, OutReady, ClrSticky,
    output InReady, OutValid, SubSum, LaneOvf, Overflow, StickyOvf
  );
endinterface

// File: rtl/psw_adder_pipe.sv
// Two-stage pipelined SIMD add/subtract over LANES independent LANE-bit two's-complement lanes.
// Optional macro PSW_SATURATE_EN clamps overflowing lanes instead of wrapping.
module psw_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input logic             clk,
  input logic             rst,
  psw_adder_pipe_if.slave bus
);
  localparam int LANES = WIDTH / LANE;

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic             s1_sub_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic [LANES-1:0] lane_ovf_r;
  logic             ovf_r;
  logic             sticky_r;

  logic             s2_load_s;
  logic             s1_adv_s;
  logic             accept_s;
  logic             xfer_s;
  logic [WIDTH-1:0] res_s;
  logic [LANES-1:0] lane_ovf_s;

  // B arrives pre-inverted for subtract, so both modes share one overflow test: equal
  // operand signs and a result sign that differs from A.
  function automatic logic [LANE:0] lane_op(input logic [LANE-1:0] a,
                                            input logic [LANE-1:0] b,
                                            input logic            cin);
    logic [LANE-1:0] r;
    logic            ovf;
    r   = a + b + {{(LANE-1){1'b0}}, cin};
    ovf = (a[LANE-1] == b[LANE-1]) && (r[LANE-1] != a[LANE-1]);
`ifdef PSW_SATURATE_EN
    if (ovf) begin
      r = a[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
    end else begin
      r = r;
    end
`endif
    return {ovf, r};
  endfunction

  assign s2_load_s = !s2_valid_r || bus.OutReady;
  assign s1_adv_s  = s1_valid_r && s2_load_s;
  assign accept_s  = bus.InValid && bus.InReady;
  assign xfer_s    = s2_valid_r && bus.OutReady;

  assign bus.InReady   = !rst && (!s1_valid_r || s2_load_s);
  assign bus.OutValid  = s2_valid_r;
  assign bus.SubSum    = sum_r;
  assign bus.LaneOvf   = lane_ovf_r;
  assign bus.Overflow  = ovf_r;
  assign bus.StickyOvf = sticky_r;

  // Per-lane arithmetic on the stage-1 operands; no carry crosses a lane boundary.
  always_comb begin
    res_s      = '0;
    lane_ovf_s = '0;
    for (int i = 0; i < LANES; i++) begin
      {lane_ovf_s[i], res_s[i*LANE +: LANE]} =
          lane_op(s1_a_r[i*LANE +: LANE], s1_b_r[i*LANE +: LANE], s1_sub_r);
    end
  end

  // Pipeline stages and sticky flag; a sticky set on transfer beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_sub_r   <= 1'b0;
      s2_valid_r <= 1'b0;
      sum_r      <= '0;
      lane_ovf_r <= '0;
      ovf_r      <= 1'b0;
      sticky_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        s1_valid_r <= 1'b1;
        s1_a_r     <= bus.A;
        s1_b_r     <= bus.B ^ {WIDTH{bus.Sub}};
        s1_sub_r   <= bus.Sub;
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end

      if (s2_load_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          sum_r      <= res_s;
          lane_ovf_r <= lane_ovf_s;
          ovf_r      <= |lane_ovf_s;
        end else begin
          sum_r      <= sum_r;
          lane_ovf_r <= lane_ovf_r;
          ovf_r      <= ovf_r;
        end
      end else begin
        s2_valid_r <= s2_valid_r;
      end

      if (xfer_s && ovf_r) begin
        sticky_r <= 1'b1;
      end else if (bus.ClrSticky) begin
        sticky_r <= 1'b0;
      end else begin
        sticky_r <= sticky_r;
      end
    end
  end
endmodule
